// File: rtl/driver_pkg.sv
// driver_pkg: shared types and timing constants for the LED-driver sequencer.
//   state_t       : sequencer state encoding (boot, readback, idle, stream)
//   *_LEN         : latch-high lengths, in SCLK cycles, of each driver command
//   *_PAUSE       : SCLK-off gaps that precede a serial transfer
//   WAIT_LEN      : SCLK-running, latch-low gap between config write and readback
package driver_pkg;

   typedef enum logic [3:0] {
      ST_STALL       = 4'd0,
      ST_PREP_CONFIG = 4'd1,
      ST_CONFIG      = 4'd2,
      ST_WAIT        = 4'd3,
      ST_PREP_DUMP   = 4'd4,
      ST_DUMP        = 4'd5,
      ST_CHECK       = 4'd6,
      ST_IDLE        = 4'd7,
      ST_STREAM      = 4'd8
   } state_t;

   // Latch-high lengths that select the driver command.
   localparam int FCWRTEN_LEN   = 15;
   localparam int READFC_LEN    = 11;
   localparam int WRTFC_LEN     = 5;
   localparam int WRTGS_LEN     = 1;
   localparam int LATGS_LEN     = 3;
   localparam int LINERESET_LEN = 7;

   // Gaps around serial transfers.
   localparam int WRTFC_PAUSE  = 1;
   localparam int READFC_PAUSE = 5;
   localparam int WAIT_LEN     = 6;

endpackage

// File: rtl/driver_readback.sv
// driver_readback: captures the function-control word read back from the
// currently selected driver and compares it with the word that was written.
//   clk_lse, nrst     : system clock, asynchronous active-low reset
//   state, cnt        : sequencer state and step counter (shift window decode)
//   driver_sout       : muxed SOUT of the selected driver, MSB first
//   serialized_conf   : reference configuration word
//   mismatch          : capture register differs from serialized_conf
module driver_readback
   import driver_pkg::*;
#(
   parameter int CONF_BITS = 48,
   parameter int CNT_W     = 7
) (
   input  logic                 clk_lse,
   input  logic                 nrst,
   input  state_t               state,
   input  logic [CNT_W-1:0]     cnt,
   input  logic                 driver_sout,
   input  logic [CONF_BITS-1:0] serialized_conf,
   output logic                 mismatch
);

   logic [CONF_BITS-1:0] capture;
   logic                 shift_en;

   // SOUT carries data only once the READFC pause has elapsed; SCLK runs on
   // exactly these cycles, so the capture sees CONF_BITS shifts per driver.
   assign shift_en = (state == ST_DUMP) && (cnt >= CNT_W'(READFC_PAUSE));

   always_ff @(posedge clk_lse or negedge nrst) begin
      if (!nrst) begin
         capture <= '0;
      end else if (shift_en) begin
         capture <= {capture[CONF_BITS-2:0], driver_sout};
      end
   end

   assign mismatch = (capture != serialized_conf);

endmodule

// File: rtl/driver_sequencer.sv
// driver_sequencer: boots N_DRIVERS PWM LED drivers, verifies each driver's
// configuration through the SOUT mux, then streams grayscale segments with
// WRTGS/LATGS and a LINERESET once per multiplex frame.
//   clk_lse, nrst        : system clock, asynchronous active-low reset
//   framebuffer_dat      : one GS bit per driver, passed to SIN on data cycles
//   framebuffer_sync     : start-of-slice pulse, leaves IDLE
//   reconfigure          : request to re-run the boot sequence
//   serialized_conf      : function-control word, MSB shifted first
//   driver_sout          : muxed SOUT of the driver selected by driver_sout_mux
//   driver_sclk/gclk/lat : driver clocks (rising mid-cycle) and latch
//   drivers_sin          : serial data, one line per driver
//   conf_done/conf_error : boot complete / per-driver readback mismatch
//   segment_start        : one-cycle pulse at the first cycle of a segment
//   line_index           : current multiplex line
module driver_sequencer
   import driver_pkg::*;
#(
   parameter int N_DRIVERS = 30,
   parameter int GS_BITS   = 9,
   parameter int CHANNELS  = 48,
   parameter int CONF_BITS = 48,
   parameter int LINES     = 8
) (
   input  logic                         clk_lse,
   input  logic                         nrst,
   input  logic [N_DRIVERS-1:0]         framebuffer_dat,
   input  logic                         framebuffer_sync,
   input  logic                         reconfigure,
   input  logic [CONF_BITS-1:0]         serialized_conf,
   input  logic                         driver_sout,
   output logic                         driver_sclk,
   output logic                         driver_gclk,
   output logic                         driver_lat,
   output logic [N_DRIVERS-1:0]         drivers_sin,
   output logic [$clog2(N_DRIVERS)-1:0] driver_sout_mux,
   output logic                         conf_done,
   output logic [N_DRIVERS-1:0]         conf_error,
   output logic                         segment_start,
   output logic [$clog2(LINES)-1:0]     line_index
);

   localparam int SEG_LEN = 2**GS_BITS + 1;
   localparam int BLANK   = SEG_LEN - GS_BITS * (CHANNELS + 1);
   localparam int M_W     = $clog2(N_DRIVERS);
   localparam int L_W     = $clog2(LINES);
   localparam int CNT_W   = $clog2(CONF_BITS + READFC_PAUSE + FCWRTEN_LEN + 1);
   localparam int SEG_W   = $clog2(SEG_LEN);
   localparam int GRP_W   = $clog2(CHANNELS + 1);
   localparam int IDX_W   = $clog2(CONF_BITS);

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [SEG_W-1:0]     seg, seg_n;
   logic [GRP_W-1:0]     grp, grp_n;
   logic [L_W-1:0]       line, line_n;
   logic [M_W-1:0]       m;
   logic                 reconf_pend;
   logic                 lat_q, lat_n;
   logic                 sclk_en, sclk_n;
   logic                 gclk_en, gclk_n;
   logic                 fb_sel, fb_sel_n;
   logic                 seg_start_q, seg_start_n;
   logic [N_DRIVERS-1:0] sin_q, sin_n;
   logic                 mismatch;

   driver_readback #(
      .CONF_BITS(CONF_BITS),
      .CNT_W    (CNT_W)
   ) u_readback (
      .clk_lse        (clk_lse),
      .nrst           (nrst),
      .state          (state),
      .cnt            (cnt),
      .driver_sout    (driver_sout),
      .serialized_conf(serialized_conf),
      .mismatch       (mismatch)
   );

   // State register. Outputs are decoded from the next state so that every
   // registered output lines up with the state it belongs to.
   always_ff @(posedge clk_lse or negedge nrst) begin
      if (!nrst) begin
         state       <= ST_STALL;
         cnt         <= '0;
         seg         <= '0;
         grp         <= '0;
         line        <= '0;
         m           <= '0;
         reconf_pend <= 1'b0;
         conf_done   <= 1'b0;
         conf_error  <= '0;
         lat_q       <= 1'b0;
         sclk_en     <= 1'b0;
         gclk_en     <= 1'b0;
         fb_sel      <= 1'b0;
         seg_start_q <= 1'b0;
         sin_q       <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         seg         <= seg_n;
         grp         <= grp_n;
         line        <= line_n;
         lat_q       <= lat_n;
         sclk_en     <= sclk_n;
         gclk_en     <= gclk_n;
         fb_sel      <= fb_sel_n;
         seg_start_q <= seg_start_n;
         sin_q       <= sin_n;
         // A request seen mid-segment is held until the segment boundary.
         reconf_pend <= (state == ST_STREAM) && (state_n == ST_STREAM) &&
                        (reconf_pend || reconfigure);
         if (state_n == ST_STALL) begin
            m          <= '0;
            conf_done  <= 1'b0;
            conf_error <= '0;
         end else if (state == ST_CHECK) begin
            conf_error[m] <= mismatch;
            if (m == M_W'(N_DRIVERS - 1)) conf_done <= 1'b1;
            else m <= m + 1'b1;
         end
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      seg_n   = seg;
      grp_n   = grp;
      line_n  = line;
      case (state)
         ST_STALL: begin
            state_n = ST_PREP_CONFIG;
            cnt_n   = '0;
         end
         ST_PREP_CONFIG:
            if (cnt == CNT_W'(FCWRTEN_LEN - 1)) begin
               state_n = ST_CONFIG;
               cnt_n   = '0;
            end
         ST_CONFIG:
            if (cnt == CNT_W'(WRTFC_PAUSE + CONF_BITS - 1)) begin
               state_n = ST_WAIT;
               cnt_n   = '0;
            end
         ST_WAIT:
            if (cnt == CNT_W'(WAIT_LEN - 1)) begin
               state_n = ST_PREP_DUMP;
               cnt_n   = '0;
            end
         ST_PREP_DUMP:
            if (cnt == CNT_W'(READFC_LEN - 1)) begin
               state_n = ST_DUMP;
               cnt_n   = '0;
            end
         ST_DUMP:
            if (cnt == CNT_W'(READFC_PAUSE + CONF_BITS - 1)) begin
               state_n = ST_CHECK;
               cnt_n   = '0;
            end
         ST_CHECK: begin
            state_n = (m == M_W'(N_DRIVERS - 1)) ? ST_IDLE : ST_PREP_DUMP;
            cnt_n   = '0;
         end
         ST_IDLE: begin
            cnt_n = '0;
            if (reconfigure) begin
               state_n = ST_STALL;
            end else if (framebuffer_sync) begin
               state_n = ST_STREAM;
               seg_n   = '0;
               grp_n   = '0;
               line_n  = '0;
            end
         end
         ST_STREAM: begin
            cnt_n = '0;
            if (seg == SEG_W'(SEG_LEN - 1)) begin
               seg_n  = '0;
               grp_n  = '0;
               line_n = (line == L_W'(LINES - 1)) ? '0 : line + 1'b1;
               if (reconf_pend || reconfigure) begin
                  state_n = ST_STALL;
                  line_n  = '0;
               end
            end else begin
               seg_n = seg + 1'b1;
               // Group counter is parked at 0 through blanking and the first
               // post-blank cycle, then wraps every CHANNELS+1 cycles.
               if (seg_n <= SEG_W'(BLANK)) grp_n = '0;
               else grp_n = (grp == GRP_W'(CHANNELS)) ? '0 : grp + 1'b1;
            end
         end
         default: begin
            state_n = ST_STALL;
            cnt_n   = '0;
         end
      endcase
   end

   // Output decode of the upcoming state/counters.
   always_comb begin
      lat_n       = 1'b0;
      sclk_n      = 1'b0;
      gclk_n      = 1'b0;
      fb_sel_n    = 1'b0;
      seg_start_n = 1'b0;
      sin_n       = '0;
      case (state_n)
         ST_PREP_CONFIG: begin
            lat_n  = 1'b1;
            sclk_n = 1'b1;
         end
         ST_CONFIG:
            if (cnt_n >= CNT_W'(WRTFC_PAUSE)) begin
               sclk_n = 1'b1;
               sin_n  = {N_DRIVERS{serialized_conf[
                           IDX_W'(CONF_BITS + WRTFC_PAUSE - 1 - int'(cnt_n))]}};
               lat_n  = (cnt_n >= CNT_W'(WRTFC_PAUSE + CONF_BITS - WRTFC_LEN));
            end
         ST_WAIT: sclk_n = 1'b1;
         ST_PREP_DUMP: begin
            lat_n  = 1'b1;
            sclk_n = 1'b1;
         end
         ST_DUMP: sclk_n = (cnt_n >= CNT_W'(READFC_PAUSE));
         ST_STREAM: begin
            gclk_n      = (seg_n != '0);
            seg_start_n = (seg_n == '0);
            if (grp_n != '0) begin
               sclk_n   = 1'b1;
               fb_sel_n = 1'b1;
            end
            lat_n = (grp_n >= GRP_W'(CHANNELS - WRTGS_LEN + 1));
            if (line_n == L_W'(LINES - 1)) begin
               if (seg_n >= SEG_W'(SEG_LEN - LINERESET_LEN)) lat_n = 1'b1;
            end else begin
               if (seg_n >= SEG_W'(SEG_LEN - LATGS_LEN)) lat_n = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Enables change only while clk_lse is high, so the gated clocks are
   // glitch-free and rise mid-cycle, half a period after SIN/LAT settle.
   assign driver_sclk     = sclk_en & ~clk_lse;
   assign driver_gclk     = gclk_en & ~clk_lse;
   assign driver_lat      = lat_q;
   // Grayscale data goes straight from the framebuffer on SCLK cycles.
   assign drivers_sin     = fb_sel ? framebuffer_dat : sin_q;
   assign driver_sout_mux = m;
   assign segment_start   = seg_start_q;
   assign line_index      = line;

endmodule
